// File: rtl/apb_master_pkg.sv
// apb_master_pkg: shared types and constants for the APB requester.
// Build option: APB_TIMEOUT_EN (enables the ACCESS-phase timeout counter).
package apb_master_pkg;

    // Requester phases
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Word offsets of the two halves of a 64-bit block
    localparam logic [3:0] LO_OFS = 4'h0;
    localparam logic [3:0] HI_OFS = 4'h1;

    // APB beat width and DES block width
    localparam int APB_DATA_W = 32;
    localparam int BLOCK_W    = 64;

    // Low address nibble for a given beat of a wide transfer
    function automatic logic [3:0] beat_ofs(input logic beat);
        return beat ? HI_OFS : LO_OFS;
    endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// apb_timeout_cnt: clear/increment counter that flags the increment which
// brings the count to TIMEOUT_CYCLES. Only present when APB_TIMEOUT_EN is
// defined; without it the module is not compiled at all.
`ifdef APB_TIMEOUT_EN
module apb_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic expire_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             at_last;

    assign at_last  = (cnt_q == LAST);
    // Expiry fires on the increment that would reach TIMEOUT_CYCLES
    assign expire_o = inc_i && at_last;

    // Count stalled ACCESS cycles; clear wins over increment, stop at the limit
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && !at_last) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/apb_master.sv
// apb_master: valid/ready command port to APB SETUP/ACCESS transfers with a
// one-cycle response. Wide commands move a 64-bit block as two 32-bit beats
// (low word at offset 0x0, high word at 0x1).
// Build option: APB_TIMEOUT_EN adds an ACCESS-phase timeout (TIMEOUT_CYCLES).
module apb_master
    import apb_master_pkg::*;
#(
    parameter int ADDR_W         = 12,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic                  cmd_wide,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [BLOCK_W-1:0]    cmd_wdata,
    output logic                  rsp_valid,
    output logic [BLOCK_W-1:0]    rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_W-1:0]     PADDR,
    output logic [APB_DATA_W-1:0] PWDATA,
    input  logic [APB_DATA_W-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    state_t                 state_q;
    logic                   beat_q;
    logic                   wide_q;
    logic [ADDR_W-5:0]      addr_hi_q;
    logic [APB_DATA_W-1:0]  wdata_hi_q;

    logic                   cmd_ready_q;
    logic                   rsp_valid_q;
    logic [BLOCK_W-1:0]     rsp_rdata_q;
    logic                   rsp_err_q;
    logic                   psel_q;
    logic                   penable_q;
    logic                   pwrite_q;
    logic [ADDR_W-1:0]      paddr_q;
    logic [APB_DATA_W-1:0]  pwdata_q;

    logic [ADDR_W-1:0]      paddr_first_d;
    logic                   last_beat;
    logic                   tmo_hit;

    // First-beat address: wide commands replace the low nibble with LO_OFS
    always_comb begin
        paddr_first_d = cmd_addr;
        if (cmd_wide) begin
            paddr_first_d = {cmd_addr[ADDR_W-1:4], LO_OFS};
        end
    end

    // A beat is the last one unless it is beat 0 of a wide command
    assign last_beat = !(wide_q && !beat_q);

`ifdef APB_TIMEOUT_EN
    logic rsp_timeout_q;

    apb_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk_i    (PCLK),
        .rst_i    (PRESET),
        .clr_i    (state_q == SETUP),
        .inc_i    ((state_q == ACCESS) && !PREADY),
        .expire_o (tmo_hit)
    );

    assign rsp_timeout = rsp_timeout_q;
`else
    // No timeout hardware: ACCESS waits for PREADY indefinitely
    logic [31:0] unused_timeout_cfg;
    assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
    assign tmo_hit            = 1'b0;
    assign rsp_timeout        = 1'b0;
`endif

    // Requester FSM with registered APB and response outputs
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= IDLE;
            beat_q      <= 1'b0;
            wide_q      <= 1'b0;
            addr_hi_q   <= '0;
            wdata_hi_q  <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
`ifdef APB_TIMEOUT_EN
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        state_q     <= SETUP;
                        beat_q      <= 1'b0;
                        wide_q      <= cmd_wide;
                        addr_hi_q   <= cmd_addr[ADDR_W-1:4];
                        wdata_hi_q  <= cmd_wdata[BLOCK_W-1:APB_DATA_W];
                        cmd_ready_q <= 1'b0;
                        rsp_rdata_q <= '0;
                        psel_q      <= 1'b1;
                        penable_q   <= 1'b0;
                        pwrite_q    <= cmd_write;
                        paddr_q     <= paddr_first_d;
                        pwdata_q    <= cmd_wdata[APB_DATA_W-1:0];
                    end
                end

                SETUP: begin
                    state_q   <= ACCESS;
                    penable_q <= 1'b1;
                end

                ACCESS: begin
                    if (PREADY) begin
                        if (!pwrite_q) begin
                            if (beat_q) begin
                                rsp_rdata_q[BLOCK_W-1:APB_DATA_W] <= PRDATA;
                            end else begin
                                rsp_rdata_q[APB_DATA_W-1:0] <= PRDATA;
                            end
                        end
                        if (PSLVERR || last_beat) begin
                            state_q     <= RESP;
                            psel_q      <= 1'b0;
                            penable_q   <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= PSLVERR;
                        end else begin
                            // Second beat re-enters SETUP with PENABLE low
                            state_q   <= SETUP;
                            beat_q    <= 1'b1;
                            penable_q <= 1'b0;
                            paddr_q   <= {addr_hi_q, beat_ofs(1'b1)};
                            pwdata_q  <= wdata_hi_q;
                        end
                    end else if (tmo_hit) begin
                        // Completer never answered: abandon the whole command
                        state_q     <= RESP;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
`ifdef APB_TIMEOUT_EN
                        rsp_timeout_q <= 1'b1;
`endif
                    end
                end

                RESP: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
                    rsp_timeout_q <= 1'b0;
`endif
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed bench for apb_master. Inputs change 1 ns after a
// rising edge; outputs are sampled at that same point, so "after edge N+k"
// shows the phase the completer samples at edge N+k+1.
module tb_apb_master;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic        cmd_wide;
    logic [11:0] cmd_addr;
    logic [63:0] cmd_wdata;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int n_cmp = 0;
    int n_bad = 0;

    apb_master #(
        .ADDR_W         (12),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_wide    (cmd_wide),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic wr, input logic wide, input logic [11:0] addr,
                        input logic [63:0] wdata);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_wide  = wide;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        tick();                 // edge N: command accepted
        cmd_valid = 1'b0;
        cmd_wdata = 64'h0;
        cmd_addr  = 12'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        PRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_wide  = 1'b0;
        cmd_addr  = 12'h0;
        cmd_wdata = 64'h0;
        PRDATA    = 32'h0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_psel",      64'(PSEL),      64'd0);
        chk("rst_penable",   64'(PENABLE),   64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_paddr",     64'(PADDR),     64'h0);
        chk("rst_rdata",     rsp_rdata,      64'h0);
        PRESET = 1'b0;
        tick();

        // 1: single write, zero wait states
        PREADY = 1'b1;
        send(1'b1, 1'b0, 12'h123, 64'h0000_0000_DEAD_BEEF);
        chk("t1_setup_psel",    64'(PSEL),      64'd1);
        chk("t1_setup_penable", 64'(PENABLE),   64'd0);
        chk("t1_setup_paddr",   64'(PADDR),     64'h123);
        chk("t1_setup_pwdata",  64'(PWDATA),    64'hDEAD_BEEF);
        chk("t1_setup_pwrite",  64'(PWRITE),    64'd1);
        chk("t1_busy_ready",    64'(cmd_ready), 64'd0);
        tick();
        chk("t1_acc_penable",   64'(PENABLE),   64'd1);
        chk("t1_acc_paddr",     64'(PADDR),     64'h123);
        chk("t1_acc_pwdata",    64'(PWDATA),    64'hDEAD_BEEF);
        chk("t1_acc_rsp_valid", 64'(rsp_valid), 64'd0);
        tick();
        chk("t1_rsp_valid",     64'(rsp_valid), 64'd1);
        chk("t1_rsp_err",       64'(rsp_err),   64'd0);
        chk("t1_rsp_psel",      64'(PSEL),      64'd0);
        chk("t1_rsp_rdata",     rsp_rdata,      64'h0);
        tick();
        chk("t1_after_valid",   64'(rsp_valid), 64'd0);
        chk("t1_after_ready",   64'(cmd_ready), 64'd1);

        // 2: wide read, two beats
        PRDATA = 32'h1111_1111;
        send(1'b0, 1'b1, 12'h200, 64'h0);
        chk("t2_b0_paddr",      64'(PADDR),     64'h200);
        chk("t2_b0_pwrite",     64'(PWRITE),    64'd0);
        tick();
        chk("t2_b0_penable",    64'(PENABLE),   64'd1);
        tick();
        chk("t2_b1_setup_psel", 64'(PSEL),      64'd1);
        chk("t2_b1_setup_pen",  64'(PENABLE),   64'd0);
        chk("t2_b1_paddr",      64'(PADDR),     64'h201);
        PRDATA = 32'h2222_2222;
        tick();
        chk("t2_b1_penable",    64'(PENABLE),   64'd1);
        chk("t2_b1_rsp_valid",  64'(rsp_valid), 64'd0);
        tick();
        chk("t2_rsp_valid",     64'(rsp_valid), 64'd1);
        chk("t2_rsp_rdata",     rsp_rdata,      64'h2222_2222_1111_1111);
        chk("t2_rsp_err",       64'(rsp_err),   64'd0);
        tick();
        chk("t2_after_valid",   64'(rsp_valid), 64'd0);

        // 3: wide write, error on beat 0 (low nibble of address ignored)
        PSLVERR = 1'b1;
        send(1'b1, 1'b1, 12'h3A7, 64'hCAFE_F00D_0BAD_C0DE);
        chk("t3_b0_paddr",      64'(PADDR),     64'h3A0);
        chk("t3_b0_pwdata",     64'(PWDATA),    64'h0BAD_C0DE);
        tick();
        chk("t3_b0_penable",    64'(PENABLE),   64'd1);
        tick();
        chk("t3_no_b1_psel",    64'(PSEL),      64'd0);
        chk("t3_rsp_valid",     64'(rsp_valid), 64'd1);
        chk("t3_rsp_err",       64'(rsp_err),   64'd1);
        chk("t3_rsp_timeout",   64'(rsp_timeout), 64'd0);
        PSLVERR = 1'b0;
        tick();
        chk("t3_after_ready",   64'(cmd_ready), 64'd1);
        chk("t3_after_psel",    64'(PSEL),      64'd0);

        // 4: single read with three wait states
        PREADY = 1'b0;
        PRDATA = 32'h5A5A_0001;
        send(1'b0, 1'b0, 12'h0AB, 64'h0);
        tick();
        chk("t4_acc0_penable",  64'(PENABLE),   64'd1);
        tick();
        chk("t4_wait1_paddr",   64'(PADDR),     64'h0AB);
        tick();
        chk("t4_wait2_psel",    64'(PSEL),      64'd1);
        tick();
        chk("t4_wait3_paddr",   64'(PADDR),     64'h0AB);
        chk("t4_wait3_pen",     64'(PENABLE),   64'd1);
        chk("t4_wait3_valid",   64'(rsp_valid), 64'd0);
        PREADY = 1'b1;
        tick();
        chk("t4_rsp_valid",     64'(rsp_valid), 64'd1);
        chk("t4_rsp_rdata",     rsp_rdata,      64'h0000_0000_5A5A_0001);
        tick();

        // 5: PREADY never asserted
        PREADY = 1'b0;
        send(1'b0, 1'b0, 12'h0F0, 64'h0);
        tick();
`ifdef APB_TIMEOUT_EN
        for (int i = 0; i < 15; i++) tick();
        chk("t5_last_wait_psel", 64'(PSEL),        64'd1);
        chk("t5_last_wait_vld",  64'(rsp_valid),   64'd0);
        tick();
        chk("t5_tmo_psel",       64'(PSEL),        64'd0);
        chk("t5_tmo_penable",    64'(PENABLE),     64'd0);
        chk("t5_tmo_valid",      64'(rsp_valid),   64'd1);
        chk("t5_tmo_err",        64'(rsp_err),     64'd1);
        chk("t5_tmo_timeout",    64'(rsp_timeout), 64'd1);
        tick();
        chk("t5_after_ready",    64'(cmd_ready),   64'd1);
`else
        for (int i = 0; i < 30; i++) tick();
        chk("t5_hold_psel",      64'(PSEL),        64'd1);
        chk("t5_hold_penable",   64'(PENABLE),     64'd1);
        chk("t5_hold_valid",     64'(rsp_valid),   64'd0);
        PREADY = 1'b1;
        tick();
        chk("t5_late_valid",     64'(rsp_valid),   64'd1);
        chk("t5_late_err",       64'(rsp_err),     64'd0);
        chk("t5_late_timeout",   64'(rsp_timeout), 64'd0);
        tick();
`endif

        // 6: reset during ACCESS of a wide write
        PREADY = 1'b0;
        send(1'b1, 1'b1, 12'h400, 64'h1234_5678_9ABC_DEF0);
        tick();
        tick();
        chk("t6_in_access",      64'(PENABLE),   64'd1);
        PRESET = 1'b1;
        tick();
        chk("t6_rst_psel",       64'(PSEL),      64'd0);
        chk("t6_rst_penable",    64'(PENABLE),   64'd0);
        chk("t6_rst_valid",      64'(rsp_valid), 64'd0);
        chk("t6_rst_ready",      64'(cmd_ready), 64'd1);
        PRESET = 1'b0;
        PREADY = 1'b1;
        tick();
        chk("t6_post_valid",     64'(rsp_valid), 64'd0);
        chk("t6_post_psel",      64'(PSEL),      64'd0);

        // 7: wide write, zero wait states, high beat data
        send(1'b1, 1'b1, 12'h510, 64'h8765_4321_0FED_CBA9);
        chk("t7_b0_pwdata",      64'(PWDATA),    64'h0FED_CBA9);
        tick();
        tick();
        chk("t7_b1_paddr",       64'(PADDR),     64'h511);
        chk("t7_b1_pwdata",      64'(PWDATA),    64'h8765_4321);
        tick();
        chk("t7_b1_acc_paddr",   64'(PADDR),     64'h511);
        tick();
        chk("t7_rsp_valid",      64'(rsp_valid), 64'd1);
        chk("t7_rsp_rdata",      rsp_rdata,      64'h0);
        chk("t7_rsp_err",        64'(rsp_err),   64'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
